fu_status_table: RTL and testbench
==================================

FU_STATUS_TABLE -- requirements
Module: fu_status_table

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, meaning number of functional-unit rows; FU id width FU_ID_W = $clog2(NUM_FU).
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning number of architectural registers; register id width REG_ID_W = $clog2(NUM_REGS).
REQ-003 SHALL have ports CLK in 1 (the single clock) and RST in 1; reset is synchronous and active-high.
REQ-004 SHALL have port disp_valid in 1, meaning a dispatch request is present.
REQ-005 SHALL have port disp_fu in FU_ID_W, meaning the target FU row.
REQ-006 SHALL have ports disp_rd, disp_rs1, disp_rs2 in REG_ID_W each, meaning destination and sources.
REQ-007 SHALL have port disp_ready out 1, meaning the dispatch is accepted this cycle when disp_valid is also high.
REQ-008 SHALL have port issue_en in NUM_FU, meaning one-hot: that FU reads its operands this cycle.
REQ-009 SHALL have ports wb_valid in 1 and wb_fu in FU_ID_W, meaning that FU completes and writes back this cycle.
REQ-010 SHALL have port wb_ready out 1, meaning the writeback is accepted.
REQ-011 SHALL have port fu_busy out NUM_FU, meaning per-row busy.
REQ-012 SHALL have port fu_can_issue out NUM_FU, meaning busy, both operands ready, not yet issued.
REQ-013 SHALL have port fust out NUM_FU x fust_row_t, meaning the full row state.

Function
REQ-014 Each row SHALL hold busy, issued, r, r1, r2, t1, t2 (producer FU ids), rdy1, rdy2.
REQ-015 The result-status table SHALL hold per-register pending (1) and producer FU id (FU_ID_W).
REQ-016 disp_ready SHALL be !fu_busy[disp_fu] && !(pending[disp_rd] && !wb_clears_rd), where wb_clears_rd = wb accepted && producer[disp_rd]==wb_fu; a row freed by wb in the same cycle is NOT reusable that cycle.
REQ-017 On accepted dispatch, the row SHALL be written at the next CLK edge: busy=1, issued=0, r/r1/r2 from the ports, and pending[disp_rd]=1 with producer=disp_fu, unless disp_rd==0.
REQ-018 For each source, rdy SHALL be 1 if the register is 0, not pending, or its producer is being written back this cycle (bypass); otherwise rdy=0 and t=the producer id.
REQ-019 fu_can_issue[i] SHALL be busy && !issued && rdy1 && rdy2 (combinational from registered state).
REQ-020 issue_en[i] SHALL set issued=1 at the next edge; issue_en on a row without fu_can_issue SHALL be ignored.
REQ-021 On accepted wb, the row wb_fu SHALL clear busy and issued; pending of its r SHALL clear only if producer still equals wb_fu; every row with t1==wb_fu and !rdy1 SHALL set rdy1=1, and likewise for t2/rdy2.
REQ-022 wb_valid on a non-busy or non-issued row SHALL be ignored and wb_ready SHALL be 0.
REQ-023 Register 0 SHALL never become pending.
REQ-024 Dispatch, issue and wb in the same cycle to distinct rows SHALL all take effect.

Reset
REQ-025 While RST is high at a CLK edge, all rows SHALL clear to zero, all pending SHALL clear to 0, and fu_busy, fu_can_issue SHALL be 0; requests in that cycle SHALL be dropped, including mid-operation ones.

Configuration
REQ-026 With FUST_WAR_CHECK_EN defined, wb_ready SHALL be 0 while any other busy, non-issued row has (r1==r of wb_fu && rdy1) or (r2==r of wb_fu && rdy2), i.e. a WAR stall; without it, wb_ready SHALL depend only on REQ-022.

Structure
REQ-027 fust_row_t, the result-status entry type, and the NUM_FU/NUM_REGS defaults SHALL live in the shared types package, parametrised generalisations of the existing scalar/matrix row types.
REQ-028 A sub-module fust_result_status (per-register pending/producer table) SHALL be instantiated.

Verification
REQ-029 Reset, then dispatch FU0 rd=5 rs=1,2 -> next cycle fu_busy=0001, fu_can_issue=0001, pending[5]=1.
REQ-030 FU0 writes r5 pending; dispatch FU1 rs1=5 -> t1=0, rdy1=0; wb FU0 -> next cycle rdy1=1, fu_can_issue[1]=1.
REQ-031 Dispatch FU2 rd=5 while r5 pending from FU0 and no wb -> disp_ready=0; same with wb FU0 in that cycle -> accepted, producer[5]=2.
REQ-032 Dispatch FU1 rs1=5 in the same cycle as wb FU0 (producer of r5) -> rdy1=1 immediately (bypass).
REQ-033 With FUST_WAR_CHECK_EN: FU1 unissued and reading r7 ready, FU0 writing r7 issues wb -> wb_ready=0 until FU1 issues, then 1.
REQ-034 RST asserted with 3 rows busy and a dispatch pending -> next cycle all outputs 0 and no pending registers.

Source files
------------

// File: rtl/fu_status_table_pkg.sv
// Shared scoreboard types: FU status row, result-status entry, table defaults.
// Field widths follow the default table dimensions below.
package fu_status_table_pkg;

  localparam int FUST_NUM_FU   = 4;
  localparam int FUST_NUM_REGS = 32;
  localparam int FUST_FU_ID_W  = $clog2(FUST_NUM_FU);
  localparam int FUST_REG_ID_W = $clog2(FUST_NUM_REGS);

  typedef logic [FUST_FU_ID_W-1:0]  fu_id_t;
  typedef logic [FUST_REG_ID_W-1:0] reg_id_t;

  typedef struct packed {
    logic    busy;
    logic    issued;
    reg_id_t r;
    reg_id_t r1;
    reg_id_t r2;
    fu_id_t  t1;
    fu_id_t  t2;
    logic    rdy1;
    logic    rdy2;
  } fust_row_t;

  typedef struct packed {
    logic   pending;
    fu_id_t producer;
  } rs_entry_t;

  // A source is usable if it is r0, has no outstanding writer, or its writer retires now.
  function automatic logic src_ready(input reg_id_t rs, input rs_entry_t e,
                                     input logic wb_acc, input fu_id_t wb_fu);
    return (rs == '0) || !e.pending || (wb_acc && (e.producer == wb_fu));
  endfunction

endpackage

// File: rtl/fust_result_status.sv
// Per-register pending/producer table; updates one cycle after set/clear, no backpressure.
// A set in the same cycle as a clear of the same register wins; r0 is never marked pending.
module fust_result_status
  import fu_status_table_pkg::*;
#(
  parameter int NUM_FU   = FUST_NUM_FU,
  parameter int NUM_REGS = FUST_NUM_REGS,
  localparam int FU_ID_W  = $clog2(NUM_FU),
  localparam int REG_ID_W = $clog2(NUM_REGS)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           i_set_vld,
  input  logic [REG_ID_W-1:0]            i_set_reg,
  input  logic [FU_ID_W-1:0]             i_set_fu,
  input  logic                           i_clr_vld,
  input  logic [REG_ID_W-1:0]            i_clr_reg,
  input  logic [FU_ID_W-1:0]             i_clr_fu,
  output rs_entry_t [NUM_REGS-1:0]       o_rs
);

  rs_entry_t [NUM_REGS-1:0] r_rs;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rs <= '0;
    end else begin
      for (int g = 1; g < NUM_REGS; g++) begin
        if (i_set_vld && (i_set_reg == REG_ID_W'(g))) begin
          r_rs[g].pending  <= 1'b1;
          r_rs[g].producer <= i_set_fu;
        end else if (i_clr_vld && (i_clr_reg == REG_ID_W'(g)) &&
                     (r_rs[g].producer == i_clr_fu)) begin
          r_rs[g].pending <= 1'b0;
        end
      end
    end
  end

  assign o_rs = r_rs;

endmodule

// File: rtl/fu_status_table.sv
// Scoreboard FU status table: dispatch/issue/writeback take effect at the next edge; stalls via disp_ready/wb_ready.
// Optional WAR writeback stall enabled by defining FUST_WAR_CHECK_EN.
module fu_status_table
  import fu_status_table_pkg::*;
#(
  parameter int NUM_FU   = FUST_NUM_FU,
  parameter int NUM_REGS = FUST_NUM_REGS,
  localparam int FU_ID_W  = $clog2(NUM_FU),
  localparam int REG_ID_W = $clog2(NUM_REGS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      disp_valid,
  input  logic [FU_ID_W-1:0]        disp_fu,
  input  logic [REG_ID_W-1:0]       disp_rd,
  input  logic [REG_ID_W-1:0]       disp_rs1,
  input  logic [REG_ID_W-1:0]       disp_rs2,
  output logic                      disp_ready,
  input  logic [NUM_FU-1:0]         issue_en,
  input  logic                      wb_valid,
  input  logic [FU_ID_W-1:0]        wb_fu,
  output logic                      wb_ready,
  output logic [NUM_FU-1:0]         fu_busy,
  output logic [NUM_FU-1:0]         fu_can_issue,
  output fust_row_t [NUM_FU-1:0]    fust
);

  fust_row_t [NUM_FU-1:0]   r_row;
  rs_entry_t [NUM_REGS-1:0] w_rs;
  logic w_wb_ok, w_war_stall, w_wb_acc, w_rd_clr, w_disp_acc, w_rdy1, w_rdy2;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_busy[i]      = r_row[i].busy;
      fu_can_issue[i] = r_row[i].busy && !r_row[i].issued && r_row[i].rdy1 && r_row[i].rdy2;
    end
  end

  assign w_wb_ok = wb_valid && r_row[wb_fu].busy && r_row[wb_fu].issued;

`ifdef FUST_WAR_CHECK_EN
  // Hold the writeback while an unissued reader still needs the old value of its register.
  always_comb begin
    w_war_stall = 1'b0;
    for (int j = 0; j < NUM_FU; j++) begin
      if ((FU_ID_W'(j) != wb_fu) && r_row[j].busy && !r_row[j].issued &&
          (((r_row[j].r1 == r_row[wb_fu].r) && r_row[j].rdy1) ||
           ((r_row[j].r2 == r_row[wb_fu].r) && r_row[j].rdy2)))
        w_war_stall = 1'b1;
    end
  end
`else
  assign w_war_stall = 1'b0;
`endif

  assign w_wb_acc   = w_wb_ok && !w_war_stall;
  assign wb_ready   = w_wb_acc;
  assign w_rd_clr   = w_wb_acc && (w_rs[disp_rd].producer == wb_fu);
  assign disp_ready = !r_row[disp_fu].busy && !(w_rs[disp_rd].pending && !w_rd_clr);
  assign w_disp_acc = disp_valid && disp_ready;
  assign w_rdy1     = src_ready(disp_rs1, w_rs[disp_rs1], w_wb_acc, wb_fu);
  assign w_rdy2     = src_ready(disp_rs2, w_rs[disp_rs2], w_wb_acc, wb_fu);

  fust_result_status #(.NUM_FU(NUM_FU), .NUM_REGS(NUM_REGS)) u_rs (
    .CLK       (CLK),
    .RST       (RST),
    .i_set_vld (w_disp_acc),
    .i_set_reg (disp_rd),
    .i_set_fu  (disp_fu),
    .i_clr_vld (w_wb_acc),
    .i_clr_reg (r_row[wb_fu].r),
    .i_clr_fu  (wb_fu),
    .o_rs      (w_rs)
  );

  // Later assignments win: the dispatched row overwrites any wakeup on its own stale fields.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_row <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_wb_acc && (r_row[i].t1 == wb_fu) && !r_row[i].rdy1) r_row[i].rdy1 <= 1'b1;
        if (w_wb_acc && (r_row[i].t2 == wb_fu) && !r_row[i].rdy2) r_row[i].rdy2 <= 1'b1;
        if (issue_en[i] && fu_can_issue[i]) r_row[i].issued <= 1'b1;
        if (w_wb_acc && (wb_fu == FU_ID_W'(i))) begin
          r_row[i].busy   <= 1'b0;
          r_row[i].issued <= 1'b0;
        end
        if (w_disp_acc && (disp_fu == FU_ID_W'(i))) begin
          r_row[i].busy   <= 1'b1;
          r_row[i].issued <= 1'b0;
          r_row[i].r      <= disp_rd;
          r_row[i].r1     <= disp_rs1;
          r_row[i].r2     <= disp_rs2;
          r_row[i].rdy1   <= w_rdy1;
          r_row[i].rdy2   <= w_rdy2;
          r_row[i].t1     <= w_rdy1 ? '0 : w_rs[disp_rs1].producer;
          r_row[i].t2     <= w_rdy2 ? '0 : w_rs[disp_rs2].producer;
        end
      end
    end
  end

  assign fust = r_row;

endmodule

// File: tb/tb_fu_status_table.sv
// Directed checks of fu_status_table: dispatch, bypass, wakeup, stalls, reset, WAR option.
module tb_fu_status_table;
  import fu_status_table_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  logic disp_valid;
  logic [1:0] disp_fu;
  logic [4:0] disp_rd, disp_rs1, disp_rs2;
  logic disp_ready;
  logic [3:0] issue_en;
  logic wb_valid;
  logic [1:0] wb_fu;
  logic wb_ready;
  logic [3:0] fu_busy, fu_can_issue;
  fust_row_t [3:0] fust;

  int n_vec = 0;
  int n_err = 0;
  logic anyp;

  always #5 CLK = ~CLK;

  fu_status_table dut (
    .CLK(CLK), .RST(RST),
    .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_rd(disp_rd),
    .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_ready(disp_ready),
    .issue_en(issue_en), .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_ready(wb_ready),
    .fu_busy(fu_busy), .fu_can_issue(fu_can_issue), .fust(fust)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    issue_en   = '0;
    wb_valid   = 1'b0;
  endtask

  task automatic disp(input logic [1:0] fu, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2);
    disp_valid = 1'b1;
    disp_fu    = fu;
    disp_rd    = rd;
    disp_rs1   = rs1;
    disp_rs2   = rs2;
  endtask

  initial begin
    idle();
    disp_fu = '0; disp_rd = '0; disp_rs1 = '0; disp_rs2 = '0; wb_fu = '0;
    RST = 1'b1;
    step(); step();
    RST = 1'b0;
    chk("rst_busy", fu_busy, 0);
    chk("rst_can", fu_can_issue, 0);
    chk("rst_fust", fust, 0);
    wb_valid = 1'b1; wb_fu = 2'd0; settle();
    chk("rst_wb_ready", wb_ready, 0);
    idle();

    // FU0: r5 <- r1, r2
    disp(0, 5, 1, 2); settle();
    chk("d0_ready", disp_ready, 1);
    step(); idle();
    chk("d0_busy", fu_busy, 4'b0001);
    chk("d0_can", fu_can_issue, 4'b0001);
    chk("d0_pend5", dut.w_rs[5].pending, 1);
    chk("d0_prod5", dut.w_rs[5].producer, 0);

    wb_valid = 1'b1; wb_fu = 2'd0; settle();
    chk("wb_unissued", wb_ready, 0);
    idle();

    disp(2, 5, 3, 4); settle();
    chk("waw_stall", disp_ready, 0);
    disp(1, 6, 5, 0); settle();
    chk("d1_ready", disp_ready, 1);
    step(); idle();
    chk("d1_rdy1", fust[1].rdy1, 0);
    chk("d1_t1", fust[1].t1, 0);
    chk("d1_rdy2", fust[1].rdy2, 1);
    chk("d1_can", fu_can_issue, 4'b0001);

    issue_en = 4'b0001; step(); idle();
    chk("iss0", fust[0].issued, 1);
    chk("iss0_can", fu_can_issue, 0);
    issue_en = 4'b0010; step(); idle();
    chk("iss_ignored", fust[1].issued, 0);

    // wb FU0 with a dispatch: freed row not reusable, r5 WAW cleared, bypass on r5
    wb_valid = 1'b1; wb_fu = 2'd0;
    disp(0, 8, 1, 2); settle();
    chk("reuse_freed", disp_ready, 0);
    disp(2, 5, 5, 0); settle();
    chk("waw_clear", disp_ready, 1);
    chk("wb0_ready", wb_ready, 1);
    step(); idle();
    chk("wb0_busy", fu_busy, 4'b0110);
    chk("wb0_prod5", dut.w_rs[5].producer, 2);
    chk("wb0_pend5", dut.w_rs[5].pending, 1);
    chk("wakeup", fust[1].rdy1, 1);
    chk("bypass", fust[2].rdy1, 1);
    chk("wb0_can", fu_can_issue, 4'b0110);

    issue_en = 4'b0010; step(); idle();
    chk("iss1_can", fu_can_issue, 4'b0100);

    // dispatch, issue and writeback to distinct rows in one cycle
    wb_valid = 1'b1; wb_fu = 2'd1; issue_en = 4'b0100;
    disp(3, 7, 6, 5); settle();
    chk("tri_disp", disp_ready, 1);
    chk("tri_wb", wb_ready, 1);
    step(); idle();
    chk("tri_busy", fu_busy, 4'b1100);
    chk("tri_iss", fust[2].issued, 1);
    chk("tri_byp", fust[3].rdy1, 1);
    chk("tri_rdy2", fust[3].rdy2, 0);
    chk("tri_t2", fust[3].t2, 2);
    chk("tri_pend6", dut.w_rs[6].pending, 0);
    chk("tri_can", fu_can_issue, 0);

    disp(0, 3, 1, 2); step(); idle();
    chk("pre_busy", fu_busy, 4'b1101);

    // reset mid-operation with a dispatch and a writeback presented
    RST = 1'b1; disp(1, 10, 0, 0); wb_valid = 1'b1; wb_fu = 2'd2;
    step();
    RST = 1'b0; idle();
    chk("rst2_busy", fu_busy, 0);
    chk("rst2_can", fu_can_issue, 0);
    chk("rst2_fust", fust, 0);
    anyp = 1'b0;
    for (int g = 0; g < 32; g++) anyp = anyp | dut.w_rs[g].pending;
    chk("rst2_pend", anyp, 0);
    wb_valid = 1'b1; wb_fu = 2'd2; settle();
    chk("rst2_wb", wb_ready, 0);
    idle();

    disp(3, 0, 0, 0); step(); idle();
    chk("r0_pend", dut.w_rs[0].pending, 0);
    chk("r0_can", fu_can_issue, 4'b1000);

    // FU1 reads r7 before FU0 writes r7
    disp(1, 9, 7, 0); step();
    disp(0, 7, 1, 2); settle();
    chk("war_disp", disp_ready, 1);
    step(); idle();
    chk("war_rdy1", fust[1].rdy1, 1);
    issue_en = 4'b0001; step(); idle();
    chk("war_can", fu_can_issue, 4'b1010);
    wb_valid = 1'b1; wb_fu = 2'd0; settle();
`ifdef FUST_WAR_CHECK_EN
    chk("war_stall", wb_ready, 0);
    step();
    chk("war_hold", wb_ready, 0);
    chk("war_busy0", fu_busy[0], 1);
    issue_en = 4'b0010; settle();
    chk("war_iss_cyc", wb_ready, 0);
    step();
    issue_en = '0; settle();
    chk("war_release", wb_ready, 1);
    step(); idle();
`else
    chk("no_war", wb_ready, 1);
    step(); idle();
    issue_en = 4'b0010; step(); idle();
`endif
    chk("war_end_busy", fu_busy, 4'b1010);
    chk("war_pend7", dut.w_rs[7].pending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
